// File: rtl/hazard_sequencer.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes and
// data-memory wait handling with a timeout halt, plus saturating perf counters.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_RUN    | normal issue; stalls/flushes decided combinationally
// S_WAIT   | data memory access outstanding, counting consecutive hold cycles
// S_HALT   | memory timed out; pipeline frozen until reset
module hazard_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_hold,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_HALT} state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              err_set;
  logic              mem_hold, load_use;
  logic              stall_inc, flush_inc;

  assign mem_hold = mem_req & ~mem_ready;
  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    state_nxt    = state;
    wait_nxt     = wait_cnt;
    err_set      = 1'b0;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_hold    = 1'b0;

    if (state == S_HALT) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_hold   = 1'b1;
    end else if (mem_hold) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_hold   = 1'b1;
      // wait_cnt is 0 in RUN, so the first hold cycle counts as one
      if (wait_cnt == WAIT_LAST) begin
        state_nxt = S_HALT;
        err_set   = 1'b1;
      end else begin
        state_nxt = S_WAIT;
        wait_nxt  = wait_cnt + 1'b1;
      end
    end else begin
      state_nxt = S_RUN;
      wait_nxt  = '0;
      if (branch_taken) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (load_use) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end
    end

    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      pipe_hold    = 1'b0;
    end
  end

  assign stall_inc = (state != S_HALT) && !pc_write;
  assign flush_inc = (state != S_HALT) && !mem_hold && branch_taken;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_RUN;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (err_set) mem_err <= 1'b1;
      if (stall_inc && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboard bench for hazard_sequencer: directed scenarios then random traffic,
// expected values from a cycle-level behavioural model pushed into a queue.
module tb_hazard_sequencer;
  localparam int TO   = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [4:0]    id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic          id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, ex_mem_read = 1'b0;
  logic          branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
  logic          pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt;

  hazard_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .pipe_hold(pipe_hold), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst; int rs1; int rs2; bit u1; bit u2; bit exr; int exrd; bit br; bit req; bit rdy;
  } stim_t;

  typedef struct {
    int pcw; int ifw; int fl; int bub; int hold; int err; int stall; int flush;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // reference model state
  bit m_halted = 0;
  bit m_err    = 0;
  int m_holds  = 0;
  int m_stall  = 0;
  int m_flush  = 0;

  task automatic chk(input string nm, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    bit   hold_req, lu;
    @(posedge clk);
    #1;
    reset = s.rst; id_rs1 = 5'(s.rs1); id_rs2 = 5'(s.rs2);
    id_uses_rs1 = s.u1; id_uses_rs2 = s.u2; ex_mem_read = s.exr; ex_rd = 5'(s.exrd);
    branch_taken = s.br; mem_req = s.req; mem_ready = s.rdy;

    hold_req = s.req && !s.rdy;
    lu = s.exr && s.exrd != 0 && ((s.u1 && s.rs1 == s.exrd) || (s.u2 && s.rs2 == s.exrd));
    e.err = m_err; e.stall = m_stall; e.flush = m_flush;
    if (s.rst)          begin e.pcw = 0; e.ifw = 0; e.fl = 1; e.bub = 1; e.hold = 0; end
    else if (m_halted)  begin e.pcw = 0; e.ifw = 0; e.fl = 0; e.bub = 0; e.hold = 1; end
    else if (hold_req)  begin e.pcw = 0; e.ifw = 0; e.fl = 0; e.bub = 0; e.hold = 1; end
    else if (s.br)      begin e.pcw = 1; e.ifw = 1; e.fl = 1; e.bub = 1; e.hold = 0; end
    else if (lu)        begin e.pcw = 0; e.ifw = 0; e.fl = 0; e.bub = 1; e.hold = 0; end
    else                begin e.pcw = 1; e.ifw = 1; e.fl = 0; e.bub = 0; e.hold = 0; end
    exp_q.push_back(e);

    if (s.rst) begin
      m_halted = 0; m_err = 0; m_holds = 0; m_stall = 0; m_flush = 0;
    end else if (!m_halted) begin
      if (e.pcw == 0 && m_stall < CMAX) m_stall++;
      if (s.br && !hold_req && m_flush < CMAX) m_flush++;
      if (hold_req) begin
        m_holds++;
        if (m_holds == TO) begin m_halted = 1; m_err = 1; end
      end else begin
        m_holds = 0;
      end
    end
  endtask

  function automatic stim_t rnd();
    stim_t s;
    s.rst  = ($urandom_range(0, 99) == 0);
    s.rs1  = $urandom_range(0, 3);
    s.rs2  = $urandom_range(0, 3);
    s.u1   = $urandom_range(0, 1) == 1;
    s.u2   = $urandom_range(0, 1) == 1;
    s.exr  = $urandom_range(0, 1) == 1;
    s.exrd = $urandom_range(0, 3);
    s.br   = ($urandom_range(0, 5) == 0);
    s.req  = ($urandom_range(0, 2) == 0);
    s.rdy  = ($urandom_range(0, 2) != 0);
    return s;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pc_write",     int'(pc_write),     e.pcw);
      chk("if_id_write",  int'(if_id_write),  e.ifw);
      chk("if_id_flush",  int'(if_id_flush),  e.fl);
      chk("id_ex_bubble", int'(id_ex_bubble), e.bub);
      chk("pipe_hold",    int'(pipe_hold),    e.hold);
      chk("mem_err",      int'(mem_err),      e.err);
      chk("stall_cnt",    int'(stall_cnt),    e.stall);
      chk("flush_cnt",    int'(flush_cnt),    e.flush);
    end
  end

  initial begin
    stim_t s;
    repeat (2) @(posedge clk);

    s = idle(); s.rst = 1; step(s);
    step(idle());

    // load-use on rs2, then same with x0 destination
    s = idle(); s.exr = 1; s.exrd = 5; s.rs2 = 5; s.u2 = 1; step(s);
    step(idle());
    s.exrd = 0; s.rs2 = 0; step(s);
    step(idle());

    // branch wins over load-use
    s = idle(); s.exr = 1; s.exrd = 7; s.rs1 = 7; s.u1 = 1; s.br = 1; step(s);
    step(idle());

    // three wait cycles with a pending branch, then release
    s = idle(); s.req = 1; s.br = 1;
    repeat (3) step(s);
    s.rdy = 1; step(s);
    step(idle());

    // timeout into halt, halt persists, reset recovers
    s = idle(); s.req = 1;
    repeat (TO) step(s);
    repeat (100) begin s = rnd(); s.rst = 0; step(s); end
    s = idle(); s.rst = 1; step(s);
    repeat (2) step(idle());

    // reset in the middle of a memory wait
    s = idle(); s.req = 1; repeat (2) step(s);
    s.rst = 1; step(s);
    step(idle());

    // counter saturation
    s = idle(); s.exr = 1; s.exrd = 3; s.rs1 = 3; s.u1 = 1;
    repeat (20) step(s);
    s = idle(); s.br = 1;
    repeat (20) step(s);
    step(idle());

    repeat (3000) step(rnd());

    @(negedge clk);
    #1;
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
